// File: rtl/jbi_dbg_mq_pkg.sv
// jbi_dbg_mq_pkg: shared defaults, mode encodings and helpers for the multi-channel debug trace queue
package jbi_dbg_mq_pkg;

    localparam int JBI_DBGMQ_NUM_CH         = 2;
    localparam int JBI_DBGMQ_WIDTH          = 64;
    localparam int JBI_DBGMQ_DEPTH          = 32;
    localparam int JBI_DBGMQ_DROP_CNT_WIDTH = 16;

    localparam logic JBI_DBGMQ_MODE_STOP  = 1'b0;
    localparam logic JBI_DBGMQ_MODE_TRACE = 1'b1;

    typedef logic [JBI_DBGMQ_DROP_CNT_WIDTH-1:0] drop_cnt_t;

    // Lost-entry counter increment that sticks at all ones instead of wrapping
    function automatic drop_cnt_t drop_sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/jbi_dbg_mq_chan.sv
// jbi_dbg_mq_chan: one circular trace queue with pointers, storage, occupancy and overflow statistics
module jbi_dbg_mq_chan
    import jbi_dbg_mq_pkg::*;
#(
    parameter int   WIDTH = JBI_DBGMQ_WIDTH,
    parameter int   DEPTH = JBI_DBGMQ_DEPTH,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    input  logic             ovf_clr,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_entry,
    output logic [AW:0]      occ,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output drop_cnt_t        drop_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    drop_cnt_t        drop_q, drop_d;
    logic             push_ok, pop_ok, ovf_evt, wr_en, rd_adv;

    // Status, push/pop qualification and next-state for pointers and statistics; flush overrides everything
    always_comb begin
        occ      = wptr_q - rptr_q;
        empty    = (wptr_q == rptr_q);
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rd_entry = mem_q[rptr_q[AW-1:0]];
        push_ok  = wr_vld && !flush;
        pop_ok   = pop && !flush && !empty;
        ovf_evt  = push_ok && full && !pop_ok;
        wr_en    = push_ok && (!full || pop_ok || mode == JBI_DBGMQ_MODE_TRACE);
        rd_adv   = pop_ok || (ovf_evt && mode == JBI_DBGMQ_MODE_TRACE);
        wptr_d   = flush ? '0 : wptr_q + (AW+1)'(wr_en);
        rptr_d   = flush ? '0 : rptr_q + (AW+1)'(rd_adv);
        ovf_d    = ovf_evt || (ovf_q && !ovf_clr);
        drop_d   = ovf_evt ? (ovf_clr ? drop_cnt_t'(1) : drop_sat_inc(drop_q)) : (ovf_clr ? '0 : drop_q);
    end

    // Pointer and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Entry storage; in trace mode a full-queue push lands on the oldest slot
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/jbi_dbg_mq.sv
// jbi_dbg_mq: NUM_CH debug trace queues drained through one round-robin arbitrated, registered read port
module jbi_dbg_mq
    import jbi_dbg_mq_pkg::*;
#(
    parameter int  NUM_CH = JBI_DBGMQ_NUM_CH,
    parameter int  WIDTH  = JBI_DBGMQ_WIDTH,
    parameter int  DEPTH  = JBI_DBGMQ_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW     = JBI_DBGMQ_DROP_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        wr_vld,
    input  logic [NUM_CH*WIDTH-1:0]  wr_data,
    input  logic [NUM_CH-1:0]        flush,
    input  logic [NUM_CH-1:0]        ovf_clr,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_data,
    output logic [CW-1:0]            rd_ch,
    output logic [NUM_CH*(AW+1)-1:0] occ,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        ovf,
    output logic [NUM_CH*DW-1:0]     drop_cnt
);

    logic [NUM_CH*WIDTH-1:0] ent;
    logic [NUM_CH-1:0]       req, pop;
    logic [CW-1:0]           arb_q, arb_d, win;
    logic                    found, load;
    int                      idx;
    logic                    rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0]        rd_data_q, rd_data_d;
    logic [CW-1:0]           rd_ch_q, rd_ch_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        jbi_dbg_mq_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .mode     (mode),
            .wr_vld   (wr_vld[c]),
            .wr_data  (wr_data[c*WIDTH +: WIDTH]),
            .flush    (flush[c]),
            .ovf_clr  (ovf_clr[c]),
            .pop      (pop[c]),
            .rd_entry (ent[c*WIDTH +: WIDTH]),
            .occ      (occ[c*(AW+1) +: AW+1]),
            .empty    (empty[c]),
            .full     (full[c]),
            .ovf      (ovf[c]),
            .drop_cnt (drop_cnt[c*DW +: DW])
        );
    end

    // Round-robin pick of the first non-empty channel at or after arb_q; a channel being flushed is not eligible
    always_comb begin
        req   = ~empty & ~flush;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(arb_q) + i) % NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
        load      = found && (!rd_vld_q || rd_rdy);
        pop       = load ? (NUM_CH'(1) << win) : '0;
        arb_d     = load ? ((int'(win) == NUM_CH - 1) ? '0 : win + 1'b1) : arb_q;
        rd_vld_d  = load || (rd_vld_q && !rd_rdy);
        rd_data_d = load ? ent[win*WIDTH +: WIDTH] : rd_data_q;
        rd_ch_d   = load ? win : rd_ch_q;
    end

    // Output stage and arbiter pointer; contents are discarded as soon as reset rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_ch_q   <= '0;
        end else begin
            arb_q     <= arb_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            rd_ch_q   <= rd_ch_d;
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;
    assign rd_ch   = rd_ch_q;

endmodule

// File: tb/tb_jbi_dbg_mq.sv
// tb_jbi_dbg_mq: directed checks of push/drain, stop and trace overflow, arbitration, flush, ovf_clr and async reset
module tb_jbi_dbg_mq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic         rd_rdy = 1'b0;
    logic [1:0]   wr_vld = '0;
    logic [1:0]   flush = '0;
    logic [1:0]   ovf_clr = '0;
    logic [127:0] wr_data = '0;
    logic         rd_vld;
    logic [63:0]  rd_data;
    logic [0:0]   rd_ch;
    logic [11:0]  occ;
    logic [1:0]   empty, full, ovf;
    logic [31:0]  drop_cnt;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    jbi_dbg_mq #(.NUM_CH(2), .WIDTH(64), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .wr_vld(wr_vld), .wr_data(wr_data),
        .flush(flush), .ovf_clr(ovf_clr), .rd_rdy(rd_rdy), .rd_vld(rd_vld),
        .rd_data(rd_data), .rd_ch(rd_ch), .occ(occ), .empty(empty), .full(full),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_vld", 64'(rd_vld), 0);
        chk("rst_occ", 64'(occ), 0);
        chk("rst_empty", 64'(empty), 2'b11);
        chk("rst_full", 64'(full), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ch", 64'(rd_ch), 0);
        rst = 1'b0;
        rd_rdy = 1'b1;
        wr_vld = 2'b01;
        wr_data[63:0] = 64'h11;
        step();
        chk("t1_no_vld_yet", 64'(rd_vld), 0);
        chk("t1_nonempty", 64'(empty[0]), 0);
        wr_data[63:0] = 64'h22;
        step();
        chk("t1_vld", 64'(rd_vld), 1);
        chk("t1_data0", rd_data, 64'h11);
        chk("t1_ch0", 64'(rd_ch), 0);
        wr_vld = '0;
        step();
        chk("t1_data1", rd_data, 64'h22);
        chk("t1_ch1", 64'(rd_ch), 0);
        chk("t1_empty", 64'(empty[0]), 1);
        step();
        chk("t1_idle", 64'(rd_vld), 0);
        rd_rdy = 1'b0;
        wr_vld = 2'b01;
        wr_data[63:0] = 64'hAA;
        step();
        wr_vld = '0;
        step();
        chk("t2_hold_aa", rd_data, 64'hAA);
        for (int i = 1; i <= 34; i++) begin
            wr_vld = 2'b10;
            wr_data[127:64] = 64'(i);
            step();
        end
        wr_vld = '0;
        chk("t2_occ", 64'(occ[11:6]), 32);
        chk("t2_full", 64'(full), 2'b10);
        chk("t2_ovf", 64'(ovf), 2'b10);
        chk("t2_drop", 64'(drop_cnt[31:16]), 2);
        chk("t2_still_aa", rd_data, 64'hAA);
        rd_rdy = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            chk("t2_drain_data", rd_data, 64'(i));
            chk("t2_drain_ch", 64'(rd_ch), 1);
        end
        step();
        chk("t2_done_vld", 64'(rd_vld), 0);
        chk("t2_done_empty", 64'(empty), 2'b11);
        ovf_clr = 2'b10;
        step();
        ovf_clr = '0;
        chk("t2_clr_ovf", 64'(ovf), 0);
        chk("t2_clr_drop", 64'(drop_cnt), 0);
        mode = 1'b1;
        rd_rdy = 1'b0;
        wr_vld = 2'b01;
        wr_data[63:0] = 64'hBB;
        step();
        wr_vld = '0;
        step();
        for (int i = 1; i <= 34; i++) begin
            wr_vld = 2'b10;
            wr_data[127:64] = 64'(i);
            step();
        end
        wr_vld = '0;
        chk("t3_occ", 64'(occ[11:6]), 32);
        chk("t3_drop", 64'(drop_cnt[31:16]), 2);
        chk("t3_ovf", 64'(ovf), 2'b10);
        chk("t3_full", 64'(full), 2'b10);
        chk("t3_hold_bb", rd_data, 64'hBB);
        rd_rdy = 1'b1;
        for (int i = 3; i <= 34; i++) begin
            step();
            chk("t3_drain_data", rd_data, 64'(i));
        end
        step();
        chk("t3_done_vld", 64'(rd_vld), 0);
        ovf_clr = 2'b10;
        step();
        ovf_clr = '0;
        mode = 1'b0;
        rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_vld = 2'b11;
            wr_data = {64'hB0 + 64'(i), 64'hA0 + 64'(i)};
            step();
        end
        wr_vld = '0;
        chk("t4_first", rd_data, 64'hA0);
        chk("t4_occ", 64'(occ), {6'd4, 6'd3});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_data", rd_data, 64'hA0);
            chk("t4_hold_ch", 64'(rd_ch), 0);
            chk("t4_hold_occ", 64'(occ), {6'd4, 6'd3});
        end
        rd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_rr_ch1", 64'(rd_ch), 1);
            chk("t4_rr_b", rd_data, 64'hB0 + 64'(i));
            if (i < 3) begin
                step();
                chk("t4_rr_ch0", 64'(rd_ch), 0);
                chk("t4_rr_a", rd_data, 64'hA1 + 64'(i));
            end
        end
        step();
        chk("t4_done_vld", 64'(rd_vld), 0);
        rd_rdy = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            wr_vld = 2'b01;
            wr_data[63:0] = 64'(i);
            step();
        end
        chk("t5_out0", rd_data, 0);
        chk("t5_occ_full", 64'(occ[5:0]), 32);
        chk("t5_full", 64'(full), 2'b01);
        wr_data[63:0] = 64'h99;
        rd_rdy = 1'b1;
        step();
        chk("t5_pp_data", rd_data, 1);
        chk("t5_pp_occ", 64'(occ[5:0]), 32);
        chk("t5_pp_ovf", 64'(ovf), 0);
        rd_rdy = 1'b0;
        flush = 2'b01;
        wr_data[63:0] = 64'h77;
        step();
        flush = '0;
        wr_vld = '0;
        chk("t5_fl_occ", 64'(occ[5:0]), 0);
        chk("t5_fl_empty", 64'(empty[0]), 1);
        chk("t5_fl_vld", 64'(rd_vld), 1);
        chk("t5_fl_data", rd_data, 1);
        for (int i = 0; i < 32; i++) begin
            wr_vld = 2'b01;
            wr_data[63:0] = 64'h40 + 64'(i);
            step();
        end
        chk("t5_refill_occ", 64'(occ[5:0]), 32);
        chk("t5_refill_ovf", 64'(ovf), 0);
        wr_data[63:0] = 64'hC0;
        step();
        chk("t5_ovf", 64'(ovf), 2'b01);
        chk("t5_drop1", 64'(drop_cnt[15:0]), 1);
        wr_data[63:0] = 64'hC1;
        ovf_clr = 2'b01;
        step();
        wr_vld = '0;
        ovf_clr = '0;
        chk("t5_clr_ovf_wins", 64'(ovf), 2'b01);
        chk("t5_clr_drop", 64'(drop_cnt[15:0]), 1);
        rd_rdy = 1'b1;
        step();
        chk("t6_drain0", rd_data, 64'h40);
        step();
        chk("t6_drain1", rd_data, 64'h41);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_vld", 64'(rd_vld), 0);
        chk("t6_async_occ", 64'(occ), 0);
        chk("t6_async_drop", 64'(drop_cnt), 0);
        chk("t6_async_ovf", 64'(ovf), 0);
        chk("t6_async_empty", 64'(empty), 2'b11);
        chk("t6_async_data", rd_data, 0);
        step();
        rst = 1'b0;
        wr_vld = 2'b10;
        wr_data[127:64] = 64'h5A;
        step();
        wr_vld = '0;
        chk("t6_post_vld0", 64'(rd_vld), 0);
        chk("t6_post_occ", 64'(occ[11:6]), 1);
        step();
        chk("t6_post_vld1", 64'(rd_vld), 1);
        chk("t6_post_data", rd_data, 64'h5A);
        chk("t6_post_ch", 64'(rd_ch), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
